// File: rtl/counter_event_capture.sv
// Timestamps rising edges of rco/load with the current counter value Q and
// buffers them in a small FIFO read over valid/ready; lost events are counted.
module counter_event_capture #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 4,
  parameter int DROP_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [WIDTH-1:0]         Q,
  input  logic                     rco,
  input  logic                     load,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_q,
  output logic [1:0]               out_type,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [DROP_W-1:0]        dropped,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = WIDTH + 2;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [EW-1:0]     mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [CW-1:0]     count_r;
  logic [DROP_W-1:0] dropped_r;
  logic              overflow_r;
  logic              rco_d_r;
  logic              load_d_r;

  logic              rco_e_s;
  logic              load_e_s;
  logic              push_s;
  logic              pop_s;
  logic              full_s;
  logic              empty_s;
  logic              write_s;
  logic              drop_s;
  logic [EW-1:0]     head_s;

  // Edge detection and push/pop/drop decisions for this cycle
  always_comb begin
    rco_e_s  = rco & ~rco_d_r;
    load_e_s = load & ~load_d_r;
    empty_s  = (count_r == {CW{1'b0}});
    full_s   = (count_r == FULL_COUNT);
    push_s   = enable & (rco_e_s | load_e_s);
    pop_s    = ~empty_s & out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    write_s  = push_s & (~full_s | pop_s);
    drop_s   = push_s & full_s & ~pop_s;
    head_s   = mem_r[rd_ptr_r];
  end

  // Head entry presented to the reader, forced to zero when nothing is held
  always_comb begin
    if (empty_s) begin
      out_valid = 1'b0;
      out_q     = {WIDTH{1'b0}};
      out_type  = 2'b00;
    end else begin
      out_valid = 1'b1;
      out_q     = head_s[WIDTH-1:0];
      out_type  = head_s[EW-1:WIDTH];
    end
  end

  // Edge-detector history, tracked regardless of enable
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rco_d_r  <= 1'b0;
      load_d_r <= 1'b0;
    end else begin
      rco_d_r  <= rco;
      load_d_r <= load;
    end
  end

  // Entry storage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {EW{1'b0}};
      end
    end else if (write_s) begin
      mem_r[wr_ptr_r] <= {load_e_s, rco_e_s, Q};
    end
  end

  // Read/write pointers and occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (write_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      case ({write_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1'b1);
        2'b01:   count_r <= count_r - CW'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Saturating drop counter and sticky overflow flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dropped_r  <= {DROP_W{1'b0}};
      overflow_r <= 1'b0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
      if (dropped_r != {DROP_W{1'b1}}) begin
        dropped_r <= dropped_r + DROP_W'(1'b1);
      end
    end
  end

  assign fifo_count = count_r;
  assign dropped    = dropped_r;
  assign overflow   = overflow_r;

endmodule

// File: tb/tb_counter_event_capture.sv
// Bench for counter_event_capture: directed scenarios plus random traffic,
// compared against a queue-based model of the event FIFO.
module tb_counter_event_capture;

  localparam int W  = 32;
  localparam int D  = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [W-1:0]  Q;
  logic          rco;
  logic          load;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_q;
  logic [1:0]    out_type;
  logic [2:0]    fifo_count;
  logic [DW-1:0] dropped;
  logic          overflow;

  counter_event_capture #(.WIDTH(W), .DEPTH(D), .DROP_W(DW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .Q(Q), .rco(rco), .load(load),
    .out_valid(out_valid), .out_ready(out_ready), .out_q(out_q), .out_type(out_type),
    .fifo_count(fifo_count), .dropped(dropped), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: queue of {type, Q}, drop count, sticky flag, previous levels
  logic [W+1:0] mq[$];
  int           m_drop;
  bit           m_ovf;
  bit           m_rco_d;
  bit           m_load_d;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_drop   = 0;
    m_ovf    = 1'b0;
    m_rco_d  = 1'b0;
    m_load_d = 1'b0;
  endtask

  task automatic model_step(input bit en, input logic [W-1:0] q, input bit r, input bit l, input bit rdy);
    bit re, le, push, pop, full;
    re   = r & ~m_rco_d;
    le   = l & ~m_load_d;
    push = en & (re | le);
    pop  = (mq.size() > 0) && rdy;
    full = (mq.size() == D);
    if (pop) void'(mq.pop_front());
    if (push) begin
      if (full && !pop) begin
        m_ovf = 1'b1;
        if (m_drop < 255) m_drop++;
      end else begin
        mq.push_back({le, re, q});
      end
    end
    m_rco_d  = r;
    m_load_d = l;
  endtask

  task automatic check_all(input string where);
    logic [W+1:0] head;
    head = (mq.size() > 0) ? mq[0] : '0;
    check_eq({where, ".valid"}, 64'(out_valid), 64'(mq.size() > 0));
    check_eq({where, ".q"},     64'(out_q),     64'(head[W-1:0]));
    check_eq({where, ".type"},  64'(out_type),  64'(head[W+1:W]));
    check_eq({where, ".count"}, 64'(fifo_count), 64'(mq.size()));
    check_eq({where, ".dropped"}, 64'(dropped), 64'(m_drop));
    check_eq({where, ".overflow"}, 64'(overflow), 64'(m_ovf));
  endtask

  task automatic cycle(input bit en, input logic [W-1:0] q, input bit r, input bit l, input bit rdy,
                       input string where);
    @(negedge clk);
    enable = en; Q = q; rco = r; load = l; out_ready = rdy;
    @(posedge clk);
    model_step(en, q, r, l, rdy);
    #1;
    check_all(where);
  endtask

  task automatic sync_reset();
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; Q = '0; rco = 1'b0; load = 1'b0; out_ready = 1'b0;
    model_reset();
    #2;
    check_eq("rst.valid", 64'(out_valid), 64'd0);
    check_eq("rst.count", 64'(fifo_count), 64'd0);
    check_eq("rst.type", 64'(out_type), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Level held 5 cycles is a single event
    for (int i = 0; i < 5; i++) cycle(1'b1, 32'h0000_00FF, 1'b1, 1'b0, 1'b0, "t2");
    check_eq("t2.count", 64'(fifo_count), 64'd1);
    check_eq("t2.type", 64'(out_type), 64'd1);
    check_eq("t2.q", 64'(out_q), 64'h0000_00FF);
    cycle(1'b1, 32'h0, 1'b0, 1'b0, 1'b1, "t2drain");

    // Simultaneous rco and load edges
    cycle(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0, "t3");
    check_eq("t3.count", 64'(fifo_count), 64'd1);
    check_eq("t3.type", 64'(out_type), 64'd3);
    check_eq("t3.q", 64'(out_q), 64'hDEAD_BEEF);
    cycle(1'b1, 32'h0, 1'b0, 1'b0, 1'b1, "t3drain");

    // Six edges into four entries
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 32'(100 + i), 1'b1, 1'b0, 1'b0, "t4");
      cycle(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, "t4");
    end
    check_eq("t4.count", 64'(fifo_count), 64'd4);
    check_eq("t4.dropped", 64'(dropped), 64'd2);
    check_eq("t4.overflow", 64'(overflow), 64'd1);
    check_eq("t4.head", 64'(out_q), 64'd100);

    // Full with simultaneous pop and push
    cycle(1'b1, 32'd200, 1'b1, 1'b0, 1'b1, "t5");
    check_eq("t5.count", 64'(fifo_count), 64'd4);
    check_eq("t5.dropped", 64'(dropped), 64'd2);
    for (int i = 0; i < 4; i++) begin
      check_eq("t5.order", 64'(out_q), (i < 3) ? 64'(101 + i) : 64'd200);
      cycle(1'b1, 32'h0, 1'b0, 1'b0, 1'b1, "t5drain");
    end
    check_eq("t5.empty", 64'(out_valid), 64'd0);

    // Edge seen while disabled is consumed, not deferred
    cycle(1'b0, 32'd7, 1'b1, 1'b0, 1'b0, "t6");
    cycle(1'b1, 32'd7, 1'b1, 1'b0, 1'b0, "t6");
    cycle(1'b1, 32'd7, 1'b1, 1'b0, 1'b0, "t6");
    check_eq("t6.count", 64'(fifo_count), 64'd0);
    cycle(1'b1, 32'd0, 1'b0, 1'b0, 1'b0, "t6");

    // Asynchronous reset with three entries held
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 32'(300 + i), 1'b0, 1'b1, 1'b0, "t1fill");
      cycle(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, "t1fill");
    end
    check_eq("t1.pre", 64'(fifo_count), 64'd3);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_eq("t1.valid", 64'(out_valid), 64'd0);
    check_eq("t1.count", 64'(fifo_count), 64'd0);
    check_eq("t1.dropped", 64'(dropped), 64'd0);
    check_eq("t1.overflow", 64'(overflow), 64'd0);
    check_eq("t1.q", 64'(out_q), 64'd0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    cycle(1'b1, 32'h1234_5678, 1'b1, 1'b0, 1'b0, "t1post");
    check_eq("t1.post", 64'(out_q), 64'h1234_5678);
    cycle(1'b1, 32'h0, 1'b0, 1'b0, 1'b1, "t1post");

    // Drop counter saturation
    for (int i = 0; i < 264; i++) begin
      cycle(1'b1, 32'(i), 1'b1, 1'b0, 1'b0, "sat");
      cycle(1'b1, 32'(i), 1'b0, 1'b0, 1'b0, "sat");
    end
    check_eq("sat.dropped", 64'(dropped), 64'd255);

    // Random traffic
    sync_reset();
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom % 8) != 0, $urandom, ($urandom % 3) == 0, ($urandom % 4) == 0,
            ($urandom % 3) == 0, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
